pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline stage register for the RISC-V datapath. It is the next-generation replacement for the fixed per-stage boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width packed payload, for example ALU result, store data, PC, PC+4, immediate, instruction, rd and zero flag. It uses a valid/ready handshake with a 2-entry skid buffer, so stalls do not create a combinational ready path, and it supports a synchronous flush that zeroes every field.

---
 rtl/pipe_stage_reg.sv | 158 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer.
// Ports: clk, reset_n (async low), flush, in_valid/in_ready/in_data
// upstream; out_valid/out_ready/out_data downstream; occupancy (0..2);
// stall_cnt/bubble_cnt perf counters, built only when
// PIPE_STAGE_PERF_EN is defined (tied to 0 otherwise).
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic in_fire;
  logic out_fire;

  // Handshake flags come only from the state register, so neither
  // ready nor valid has a combinational path through this stage.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      S_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      S_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      S_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Redirect: drop everything, including a beat in this cycle.
      state_d = S_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            // Consumer stalled: park the new beat behind main.
            state_d = S_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            // main keeps its stale value; out_valid drops.
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  // Saturating counters; flush does not clear them.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (!out_valid && out_ready && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random bench for pipe_stage_reg.
// Covers reset, streaming, backpressure, flush, async reset, counters.
module tb_pipe_stage_reg;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_data   = '0;
    reset_n   = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1
        || occupancy !== 2'd0) begin
      n_bad++;
      $display("FAIL reset: v=%b d=%h rdy=%b occ=%0d want 0/0/1/0",
               out_valid, out_data, in_ready, occupancy);
    end
    n_cmp++;
    if (stall_cnt !== '0 || bubble_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_cnt: stall=%0d bubble=%0d want 0/0",
               stall_cnt, bubble_cnt);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = W'(k);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== W'(k) || in_ready !== 1'b1
          || occupancy !== 2'd1) begin
        n_bad++;
        $display("FAIL stream[%0d]: v=%b d=%h rdy=%b occ=%0d want 1/%h/1/1",
                 k, out_valid, out_data, in_ready, occupancy, k);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h8) begin
      n_bad++;
      $display("FAIL stream_drain: v=%b occ=%0d d=%h want 0/0/8",
               out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    n_cmp++;
    if (occupancy !== 2'd1 || out_data !== 32'hA) begin
      n_bad++;
      $display("FAIL bp_a: occ=%0d d=%h want 1/a", occupancy, out_data);
    end
    in_data = 32'hB;
    step();
    n_cmp++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
      n_bad++;
      $display("FAIL bp_full: occ=%0d rdy=%b d=%h want 2/0/a",
               occupancy, in_ready, out_data);
    end
    in_data = 32'hC;
    step();
    n_cmp++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
      n_bad++;
      $display("FAIL bp_hold: occ=%0d rdy=%b d=%h want 2/0/a",
               occupancy, in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_data !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_pop1: d=%h occ=%0d rdy=%b want b/1/1",
               out_data, occupancy, in_ready);
    end
    step();
    n_cmp++;
    if (out_data !== 32'hC || occupancy !== 2'd1 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_pop2: d=%h occ=%0d v=%b want c/1/1",
               out_data, occupancy, out_valid);
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_bad++;
      $display("FAIL bp_empty: v=%b occ=%0d want 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data = 32'h22;
    step();
    in_data = 32'h33;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0
        || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush: v=%b d=%h occ=%0d rdy=%b want 0/0/0/1",
               out_valid, out_data, occupancy, in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || out_data === 32'h33) begin
        n_bad++;
        $display("FAIL flush_leak[%0d]: v=%b d=%h want v=0", k,
                 out_valid, out_data);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    step();
    in_data = 32'h66;
    step();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0
        || in_ready !== 1'b1 || stall_cnt !== '0) begin
      n_bad++;
      $display("FAIL async_rst: v=%b d=%h occ=%0d rdy=%b st=%0d",
               out_valid, out_data, occupancy, in_ready, stall_cnt);
    end
    step();
    reset_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h77;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h77 || occupancy !== 2'd1) begin
      n_bad++;
      $display("FAIL rst_capture: v=%b d=%h occ=%0d want 1/77/1",
               out_valid, out_data, occupancy);
    end
  endtask

  task automatic test_counters();
    logic [CW-1:0] exp_st;
    logic [CW-1:0] exp_bu;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h9;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) step();
`ifdef PIPE_STAGE_PERF_EN
    exp_st = 4'd15;
    exp_bu = 4'd3;
`else
    exp_st = 4'd0;
    exp_bu = 4'd0;
`endif
    n_cmp++;
    if (stall_cnt !== exp_st) begin
      n_bad++;
      $display("FAIL stall_sat: got %0d want %0d", stall_cnt, exp_st);
    end
    out_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) step();
    n_cmp++;
    if (bubble_cnt !== exp_bu || stall_cnt !== exp_st) begin
      n_bad++;
      $display("FAIL bubble: got %0d/%0d want %0d/%0d",
               bubble_cnt, stall_cnt, exp_bu, exp_st);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] exp;
    logic         inf;
    logic         outf;
    int           errs;
    errs = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_data   = $urandom;
      inf  = in_valid & in_ready;
      outf = out_valid & out_ready;
      if (outf) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          errs++;
          if (errs < 10)
            $display("FAIL rnd_extra[%0d]: d=%h with empty model", c, out_data);
        end else begin
          exp = q.pop_front();
          if (out_data !== exp) begin
            n_bad++;
            errs++;
            if (errs < 10)
              $display("FAIL rnd_data[%0d]: got %h want %h", c, out_data, exp);
          end
        end
      end
      if (inf) q.push_back(in_data);
      step();
      n_cmp++;
      if (occupancy !== 2'(q.size()) || in_ready !== (q.size() != 2)) begin
        n_bad++;
        errs++;
        if (errs < 10)
          $display("FAIL rnd_occ[%0d]: occ=%0d rdy=%b want occ=%0d",
                   c, occupancy, in_ready, q.size());
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_counters();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
